// File: rtl/sram_bist_checker.sv
// sram_bist_checker: sequential write/read-back self-test engine for a bank
// of single-port SRAM macros. Each macro is filled with a selectable pattern
// and then read back. Every word is compared against the regenerated
// expected value.
// Optional feature macro: SRAM_BIST_ERRCNT_EN builds the 16-bit saturating
// mismatch counter. Without it, err_count is tied to zero.
module sram_bist_checker #(
   parameter int          NUM_SRAMS    = 5,
   parameter int          ADDR_WIDTH   = 8,
   parameter int          DATA_WIDTH   = 32,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468
) (
   input  logic                                               clk,
   input  logic                                               resetn,
   input  logic                                               start,
   input  logic                                               abort,
   input  logic [1:0]                                         mode,
   output logic [NUM_SRAMS-1:0]                               sram_csb,
   output logic                                               sram_web,
   output logic [((DATA_WIDTH/8 > 1) ? DATA_WIDTH/8 : 1)-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]                              sram_addr,
   output logic [DATA_WIDTH-1:0]                              sram_din,
   input  logic [NUM_SRAMS*DATA_WIDTH-1:0]                    sram_dout,
   output logic                                               busy,
   output logic                                               done,
   output logic [NUM_SRAMS-1:0]                               fail,
   output logic [((NUM_SRAMS > 1) ? $clog2(NUM_SRAMS) : 1)-1:0] first_fail_ch,
   output logic [ADDR_WIDTH-1:0]                              first_fail_addr,
   output logic [15:0]                                        err_count
);

   localparam int CH_W = (NUM_SRAMS > 1) ? $clog2(NUM_SRAMS) : 1;
   localparam int FL_W = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                  state;
   logic [1:0]              mode_r;
   logic [CH_W-1:0]         ch;
   logic [CH_W-1:0]         ch_nxt;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [ADDR_WIDTH-1:0]   addr_nxt;
   logic [31:0]             lfsr;
   logic [31:0]             lfsr_nxt;
   logic [FL_W-1:0]         flush_cnt;
   logic                    last_ch;
   logic                    start_go;

   // Read-compare pipeline: one entry per cycle of macro read latency.
   logic [READ_LATENCY-1:0] pipe_vld;
   logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   pipe_exp  [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    hit;

   // Galois LFSR, x^32 + x^22 + x^2 + x + 1, shifting right.
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
   endfunction

   // Expected word for one address under the selected pattern.
   function automatic logic [DATA_WIDTH-1:0] pattern(
      input logic [1:0]            m,
      input logic [ADDR_WIDTH-1:0] a,
      input logic [31:0]           l
   );
      logic [DATA_WIDTH-1:0] rep;
      logic [DATA_WIDTH-1:0] p;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         rep[i] = a[i % ADDR_WIDTH];
      end
      case (m)
         2'd0:    p = a[0] ? DATA_WIDTH'(32'hAAAA_AAAA) : DATA_WIDTH'(32'h5555_5555);
         2'd1:    p = rep;
         2'd2:    p = ~rep;
         default: p = l[DATA_WIDTH-1:0];
      endcase
      return p;
   endfunction

   // Chip-select vector with only the given macro enabled.
   function automatic logic [NUM_SRAMS-1:0] csb_for(input logic [CH_W-1:0] c);
      logic [NUM_SRAMS-1:0] v;
      v    = '1;
      v[c] = 1'b0;
      return v;
   endfunction

   assign ch_nxt     = ch + 1'b1;
   assign addr_nxt   = addr + 1'b1;
   assign lfsr_nxt   = lfsr_step(lfsr);
   assign last_ch    = (ch == CH_W'(NUM_SRAMS - 1));
   assign start_go   = (state == IDLE) && start && !abort;
   assign sram_addr  = addr;
   assign sram_wmask = '1;

   // Sequencer: state, address/channel/LFSR counters and registered macro controls.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         mode_r    <= 2'd0;
         ch        <= '0;
         addr      <= '0;
         lfsr      <= LFSR_SEED;
         flush_cnt <= '0;
         sram_csb  <= '1;
         sram_web  <= 1'b1;
         sram_din  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state    <= IDLE;
            sram_csb <= '1;
            sram_web <= 1'b1;
            busy     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state    <= WRITE;
                     mode_r   <= mode;
                     ch       <= '0;
                     addr     <= '0;
                     lfsr     <= LFSR_SEED;
                     sram_csb <= csb_for('0);
                     sram_web <= 1'b0;
                     sram_din <= pattern(mode, '0, LFSR_SEED);
                     busy     <= 1'b1;
                  end
               end
               WRITE: begin
                  if (addr == '1) begin
                     // Switch to read-back; the pattern restarts from address 0.
                     state    <= READ;
                     addr     <= '0;
                     lfsr     <= LFSR_SEED;
                     sram_web <= 1'b1;
                  end else begin
                     addr     <= addr_nxt;
                     lfsr     <= lfsr_nxt;
                     sram_din <= pattern(mode_r, addr_nxt, lfsr_nxt);
                  end
               end
               READ: begin
                  if (addr == '1) begin
                     state     <= FLUSH;
                     flush_cnt <= '0;
                     sram_csb  <= '1;
                  end else begin
                     addr <= addr_nxt;
                     lfsr <= lfsr_nxt;
                  end
               end
               FLUSH: begin
                  // Idle cycles let the reads still in flight reach the comparator.
                  if (flush_cnt == FL_W'(READ_LATENCY - 1)) begin
                     if (last_ch) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state    <= WRITE;
                        ch       <= ch_nxt;
                        addr     <= '0;
                        lfsr     <= LFSR_SEED;
                        sram_csb <= csb_for(ch_nxt);
                        sram_web <= 1'b0;
                        sram_din <= pattern(mode_r, '0, LFSR_SEED);
                     end
                  end else begin
                     flush_cnt <= flush_cnt + 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   // Pipeline valid bits; an abort discards every read still in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pipe_vld <= '0;
      end else if (abort) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= (state == READ);
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
         end
      end
   end

   // Pipeline payload: address and expected word of each issued read.
   always_ff @(posedge clk) begin
      pipe_addr[0] <= addr;
      pipe_exp[0]  <= pattern(mode_r, addr, lfsr);
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_addr[i] <= pipe_addr[i-1];
         pipe_exp[i]  <= pipe_exp[i-1];
      end
   end

   assign rd_word = sram_dout[ch*DATA_WIDTH +: DATA_WIDTH];
   assign hit     = pipe_vld[READ_LATENCY-1] && !abort &&
                    (rd_word != pipe_exp[READ_LATENCY-1]);

   // Sticky fail flags and first-failure capture, cleared when a run starts.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fail            <= '0;
         first_fail_ch   <= '0;
         first_fail_addr <= '0;
      end else if (start_go) begin
         fail            <= '0;
         first_fail_ch   <= '0;
         first_fail_addr <= '0;
      end else if (hit) begin
         fail[ch] <= 1'b1;
         if (fail == '0) begin
            first_fail_ch   <= ch;
            first_fail_addr <= pipe_addr[READ_LATENCY-1];
         end
      end
   end

`ifdef SRAM_BIST_ERRCNT_EN
   // Saturating count of mismatched words in the current run.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_count <= 16'h0000;
      end else if (start_go) begin
         err_count <= 16'h0000;
      end else if (hit && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'h0001;
      end
   end
`else
   assign err_count = 16'h0000;
`endif

endmodule

// File: doc/sram_bist_checker.md
# sram_bist_checker

Parametrised on-chip built-in self-test engine for the OpenRAM macros on the test chip. It tests `NUM_SRAMS` macros one after another: it writes a selectable data pattern to every address of a macro, then reads every address back and compares each word against the regenerated expected value. Results are reported as sticky per-macro fail bits and first-failure capture registers, which the top level routes to GPIO and to the wishbone/LA status space. This replaces software-driven read-back checking with a hardware sweep whose channel count, depth, width and read latency are all configurable.

## Interface
Parameters:
- `NUM_SRAMS`, 5: number of macros under test.
- `ADDR_WIDTH`, 8: macro address width; depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 32: macro word width, 1..32.
- `READ_LATENCY`, 1: cycles from a read issue (csb low, web high) to valid dout; range 1..4.
- `LFSR_SEED`, 32'hACE1_2468: LFSR reload value; must be non-zero.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: starts a test run when the engine is idle.
- `abort` input 1: stops a run in progress.
- `mode` input 2: pattern select, sampled at start.
- `sram_csb` output NUM_SRAMS: per-macro chip select, active low.
- `sram_web` output 1: shared write enable, active low (0 = write).
- `sram_wmask` output DATA_WIDTH/8 (minimum 1): shared write mask, all ones.
- `sram_addr` output ADDR_WIDTH: shared address.
- `sram_din` output DATA_WIDTH: shared write data.
- `sram_dout` input NUM_SRAMS*DATA_WIDTH: concatenated read data; macro i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `busy` output 1: high while a run is active.
- `done` output 1: one-cycle pulse when a run completes normally.
- `fail` output NUM_SRAMS: sticky per-macro mismatch flags.
- `first_fail_ch` output clog2(NUM_SRAMS) (minimum 1): macro of the first mismatch.
- `first_fail_addr` output ADDR_WIDTH: address of the first mismatch.
- `err_count` output 16: count of mismatched words.

## Operation
States:
- IDLE: waits for `start`.
- WRITE: one write per cycle, addresses 0..2^A−1.
- READ: one read per cycle, addresses 0..2^A−1.
- FLUSH: READ_LATENCY cycles with no issue, so the last reads can be compared.
- DONE: one cycle.

Transitions:
- IDLE → WRITE on `start`. At the same edge:
  - `mode` is latched;
  - channel and address are set to 0;
  - `fail`, `first_fail_*` and `err_count` are cleared;
  - the LFSR is loaded with `LFSR_SEED`.
- WRITE → READ after the last address. The address returns to 0 and the LFSR is reloaded with the seed.
- READ → FLUSH after the last address.
- FLUSH → WRITE on the next channel, with the LFSR reloaded; or FLUSH → DONE after the last channel.
- DONE → IDLE.
- `abort` in any non-IDLE state returns the engine to IDLE at the next edge. All `sram_csb` go high, `done` does not pulse, and the result registers hold their values.
- `start` is ignored while busy. `abort` has priority over `start`.

Patterns (expected data E(a) for address a):
- mode 0: checkerboard. E(a) is {..AA} when a[0] is 1, otherwise {..55}, truncated to DATA_WIDTH.
- mode 1: address replicated to fill DATA_WIDTH.
- mode 2: bitwise inverse of mode 1.
- mode 3: low DATA_WIDTH bits of a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1. It advances once per issued access.

Compare:
- A pipeline of READ_LATENCY stages carries the valid bit, address and expected word of each issued read.
- At the pipeline output, the word from the active channel's `sram_dout` slice is compared with the expected word.
- On a mismatch:
  - the fail bit of that channel is set;
  - `err_count` increments, saturating at 16'hFFFF;
  - `first_fail_ch` and `first_fail_addr` are captured only on the first mismatch of the run.
- Only the active channel's `sram_csb` is ever low. Every other channel, and all channels in IDLE, FLUSH and DONE, hold csb high.

## Timing
- Reset values:
  - `sram_csb` all ones;
  - `sram_web` 1;
  - `sram_wmask` all ones;
  - `sram_addr` 0 and `sram_din` 0;
  - `busy`, `done`, `fail`, `first_fail_*` and `err_count` all 0.
- All outputs are registered.
- The first write is driven in the first cycle after the start edge.
- Each channel takes 2·2^A + READ_LATENCY cycles.
- `done` is high, and `busy` is low, in cycle NUM_SRAMS·(2^(A+1)+READ_LATENCY)+1 after the start edge. `busy` is high from cycle 1 through the last FLUSH cycle.
- The result for a read issued in cycle n is registered at the end of cycle n+READ_LATENCY.
- Reset asserted mid-run forces the reset values immediately (asynchronous). No partial result is retained.

## Configuration
- `SRAM_BIST_ERRCNT_EN` defined: the 16-bit saturating error counter is built.
- `SRAM_BIST_ERRCNT_EN` not defined: `err_count` is tied to 0 and no counter logic is built. `fail` and `first_fail_*` behave the same either way.

## Test plan
Bench configuration for all scenarios: NUM_SRAMS=2, ADDR_WIDTH=4, DATA_WIDTH=8, READ_LATENCY=1, with behavioural macro models.
- Clean run, mode 0, `start` pulsed:
  - required response: `done` pulses in cycle 67;
  - `fail`=2'b00 and `err_count`=0;
  - macro 0 csb is low only in cycles 1–32, macro 1 only in cycles 34–65.
- Stuck-at-0 on bit 3 of macro 1 at address 5, mode 0:
  - address 5 expects 8'hAA and reads 8'hA2;
  - required response: `fail`=2'b10, `first_fail_ch`=1, `first_fail_addr`=5, `err_count`=1.
- Modes 1, 2 and 3 on the clean model:
  - `sram_din` at addresses 0 and 1 is 8'h00/8'h11 in mode 1 and 8'hFF/8'hEE in mode 2;
  - in mode 3 the first write word equals `LFSR_SEED`[7:0];
  - all modes report no failures.
- Model READ_LATENCY set to 2 with the engine still at 1: mismatches occur and `fail` is nonzero. With the engine rebuilt at 2: the run is clean and `done` pulses in cycle 69.
- `abort` in cycle 20:
  - `busy` is 0 and all csb are high from cycle 21, and `done` never pulses;
  - a new `start` clears the results and the run completes.
- `resetn` low in cycle 40: all outputs reach their reset values immediately. With `SRAM_BIST_ERRCNT_EN` undefined, `err_count` stays 0 in the stuck-bit scenario.
